// File: rtl/apb_master.sv
// APB initiator: turns valid/ready commands into single APB transfers and returns rdata/error.
// Optional watchdog abort of long wait states is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              accept_s;
  logic              done_s;
  logic              abort_s;
  logic [ADDR_W-1:0] paddr_r;
  logic              pwrite_r;
  logic [31:0]       pwdata_r;
  logic [31:0]       rsp_rdata_r;
  logic              rsp_err_r;
  logic              rsp_timeout_r;

  assign accept_s = (state_r == IDLE) && cmd_valid;
  assign done_s   = (state_r == ACCESS) && pready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic [15:0] wait_cnt_r;

  // Wait-state counter: cleared while in SETUP so it starts at zero on ACCESS entry.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_r <= 16'd0;
    end else if (state_r == SETUP) begin
      wait_cnt_r <= 16'd0;
    end else if ((state_r == ACCESS) && !pready) begin
      wait_cnt_r <= wait_cnt_r + 16'd1;
    end
  end

  // A ready slave on the match cycle completes normally, so pready gates the abort.
  assign abort_s = (state_r == ACCESS) && !pready && (wait_cnt_r == TIMEOUT_C);
`else
  localparam int unused_timeout = TIMEOUT;

  assign abort_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          state_next_s = SETUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP: begin
        state_next_s = ACCESS;
      end
      ACCESS: begin
        if (pready || abort_s) begin
          state_next_s = RESP;
        end else begin
          state_next_s = ACCESS;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Command capture on accept and response capture on completion or abort.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      paddr_r       <= '0;
      pwrite_r      <= 1'b0;
      pwdata_r      <= 32'd0;
      rsp_rdata_r   <= 32'd0;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      if (accept_s) begin
        paddr_r  <= cmd_addr;
        pwrite_r <= cmd_write;
        pwdata_r <= cmd_wdata;
      end
      if (done_s) begin
        rsp_rdata_r   <= pwrite_r ? 32'd0 : prdata;
        rsp_err_r     <= pslverr;
        rsp_timeout_r <= 1'b0;
      end else if (abort_s) begin
        rsp_rdata_r   <= 32'd0;
        rsp_err_r     <= 1'b1;
        rsp_timeout_r <= 1'b1;
      end
    end
  end

  // Handshake and APB strobes decode straight from the state flops, so reset clears them at once.
  assign cmd_ready   = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign psel        = (state_r == SETUP) || (state_r == ACCESS);
  assign penable     = (state_r == ACCESS);
  assign rsp_valid   = (state_r == RESP);
  assign paddr       = paddr_r;
  assign pwrite      = pwrite_r;
  assign pwdata      = pwdata_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_timeout = rsp_timeout_r;

endmodule

// File: doc/apb_master.md
# apb_master

APB initiator that converts a simple valid/ready command interface into single APB transfers and returns read data and error status on a response interface. It sits between an internal controller (sequencer, DMA, debug bridge) and the APB slaves of the peripheral subsystem, such as the control/status register blocks. It supports one outstanding transfer at a time, honours `pready` wait states and `pslverr`, and has an optional watchdog timeout.

## Interface
- `ADDR_W`, 16: APB address width.
- `TIMEOUT`, 255: number of `pready`-low ACCESS cycles before abort; only used with `APB_MASTER_TIMEOUT_EN`; must be 1..65535.

- `pclk`  in  1  clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high at a rising edge.
- `cmd_addr`  in  ADDR_W  transfer address.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_wdata`  in  32  write data.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed when both `rsp_valid` and `rsp_ready` are high at a rising edge.
- `rsp_rdata`  out  32  read data; 0 for writes.
- `rsp_err`  out  1  slave error or timeout.
- `rsp_timeout`  out  1  transfer aborted by watchdog.
- `busy`  out  1  high in any state other than IDLE.
- `paddr`  out  ADDR_W  APB address.
- `pwrite`  out  1  APB direction.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwdata`  out  32  APB write data.
- `prdata`  in  32  APB read data.
- `pready`  in  1  APB ready.
- `pslverr`  in  1  APB error.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS, RESP.
  - **IDLE:** `cmd_ready=1`. On command accept, register addr/write/wdata into `paddr`/`pwrite`/`pwdata` and go to SETUP.
  - **SETUP:** `psel=1`, `penable=0`; unconditionally go to ACCESS.
  - **ACCESS:** `psel=1`, `penable=1`.
    - If `pready=1`: capture `rsp_rdata` (`prdata` for reads, 0 for writes) and `rsp_err=pslverr`, then go to RESP.
    - If `pready=0`: stay in ACCESS.
  - **RESP:** `psel=0`, `penable=0`, `rsp_valid=1`. On `rsp_ready`, go to IDLE.
- `cmd_ready` is low in every state except IDLE. A command presented while busy is held by the requester; it is not dropped.
- `paddr`, `pwrite` and `pwdata` are stable from SETUP through the last ACCESS cycle. They hold their last value in IDLE and RESP.
- `rsp_rdata`, `rsp_err` and `rsp_timeout` are stable while `rsp_valid` is high.
- `prdata` and `pslverr` are sampled only in an ACCESS cycle with `pready=1`; they are ignored at all other times.
- `cmd_*` inputs are sampled only at the accept edge.

## Timing
- **Reset values:** state=IDLE, `cmd_ready=1`, `psel=0`, `penable=0`, `pwrite=0`, `paddr=0`, `pwdata=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `rsp_timeout=0`, `busy=0`.
- **Zero-wait transfer:** accept at edge N; SETUP in cycle N+1; ACCESS in cycle N+2; `rsp_valid` high in cycle N+3.
- **Wait states:** each `pready`-low ACCESS cycle adds one cycle of latency.
- **Throughput:** minimum transfer period is 4 cycles (accept, SETUP, ACCESS, RESP with `rsp_ready=1`, back to IDLE).
- **Backpressure:** RESP holds for any number of cycles while `rsp_ready=0`.
- **Reset mid-operation:** reset is asynchronous. `psel`/`penable` drop immediately and any pending response is discarded.

## Configuration
- **Macro:** `APB_MASTER_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with `pready=0`.
  - When the counter equals `TIMEOUT` and `pready` is still 0, the transfer aborts and the FSM goes to RESP with `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`.
  - `pready=1` in the same cycle as the match wins: normal completion, no timeout.
- **Not defined:** no counter is present, ACCESS waits indefinitely, and `rsp_timeout` is tied to 0.

## Test plan
- **Write, zero wait:** write addr 0x10, data 0xA5A5_1234, `pready=1` → `psel` high 2 cycles with `penable` in the 2nd cycle and `pwdata=0xA5A5_1234`; `rsp_valid` 3 cycles after accept with `rsp_rdata=0`, `rsp_err=0`.
- **Read with wait states:** read addr 0x1C, `pready` low 3 ACCESS cycles, `prdata=0x0021_6948` → `rsp_rdata=0x0021_6948` at latency 6; `paddr` stable throughout.
- **Slave error:** read with `pready=1`, `pslverr=1` → `rsp_err=1`, `rsp_timeout=0`.
- **Response backpressure:** `rsp_ready=0` for 5 cycles with the next command pending → `rsp_valid` and data held, `cmd_ready=0`, next SETUP only after the handshake.
- **Timeout (macro defined, `TIMEOUT=4`):** `pready` stuck low → abort after 4 wait cycles with `rsp_err=1`, `rsp_timeout=1`. Repeat with `pready` rising exactly on the match cycle → normal completion.
- **Reset in ACCESS:** assert `reset_n` low during a waited read → `psel`/`penable` low asynchronously, no `rsp_valid`; after release a new command completes normally.
